// File: rtl/uart_tx_mch.sv
// Multi-channel UART transmitter behind a Wishbone slave port.
// Each channel has a TX FIFO, a baud divisor, control bits and an IDLE/START/DATA/STOP serializer.
module uart_tx_mch #(
  parameter int N_CH       = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_BITS  = 8,
  parameter int DIV_W      = 16,
  parameter int DIV_RESET  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [15:0]         adr_i,
  input  logic [31:0]         dat_i,
  output logic [31:0]         dat_o,
  input  logic                we_i,
  input  logic [3:0]          sel_i,
  input  logic                stb_i,
  input  logic                cyc_i,
  output logic                ack_o,
  output logic                intr_o,
  output logic [N_CH-1:0]     stx_o,
  output logic [2*N_CH-1:0]   dbg_state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

  // Handshake: a request (cyc_i & stb_i) is accepted on the edge that raises ack_o;
  // the master holds the request until it sees ack_o, and ack_o drops the cycle after.
  logic              r_ack;
  logic [31:0]       r_dat;
  logic              r_intr;
  logic              w_acc;
  logic [3:0]        w_ch;
  logic [1:0]        w_reg;
  logic [DIV_W-1:0]  w_div_mask;
  logic [31:0]       w_rdata;
  logic [31:0]       w_rd [N_CH];
  logic [N_CH-1:0]   w_irq;
  logic              w_unused;

  assign w_acc    = cyc_i & stb_i & ~r_ack;
  assign w_ch     = adr_i[7:4];
  assign w_reg    = adr_i[3:2];
  assign w_unused = ^{adr_i[15:8], adr_i[1:0], dat_i, sel_i};

  always_comb begin
    w_div_mask = '0;
    for (int b = 0; b < DIV_W; b++) w_div_mask[b] = sel_i[b/8];
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    tx_state_t              r_state;
    logic [DIV_W-1:0]       r_div;
    logic [DIV_W-1:0]       r_baud;
    logic [2:0]             r_ctrl;
    logic                   r_ovf;
    logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wptr;
    logic [AW-1:0]          r_rptr;
    logic [LW-1:0]          r_level;
    logic [DATA_BITS-1:0]   r_shift;
    logic [2:0]             r_bitcnt;
    logic                   r_tx;
    logic [DIV_W-1:0]       w_dmax;
    logic [DIV_W-1:0]       w_reload;
    logic [31:0]            w_status;
    logic w_sel, w_push, w_pop, w_push_ok, w_empty, w_full, w_bit_end;
    logic w_wr_div, w_wr_ctrl;

    assign w_sel     = w_acc & (w_ch == 4'(c));
    assign w_push    = w_sel & we_i & (w_reg == 2'd0) & sel_i[0];
    assign w_wr_div  = w_sel & we_i & (w_reg == 2'd1);
    assign w_wr_ctrl = w_sel & we_i & (w_reg == 2'd3) & sel_i[0];
    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == LW'(FIFO_DEPTH));
    assign w_dmax    = (r_div == '0) ? DIV_W'(1) : r_div;
    assign w_reload  = w_dmax - DIV_W'(1);
    assign w_bit_end = (r_baud == '0);
    // A frame is fetched from IDLE, or straight out of STOP for back-to-back frames.
    assign w_pop     = r_ctrl[0] & ~w_empty &
                       ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bit_end));
    assign w_push_ok = w_push & (~w_full | w_pop);

    always_ff @(posedge clk_i) begin
      if (w_push_ok) r_mem[r_wptr] <= dat_i[DATA_BITS-1:0];
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_div   <= DIV_W'(DIV_RESET);
        r_ctrl  <= '0;
        r_ovf   <= 1'b0;
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_level <= '0;
      end else begin
        if (w_wr_div)  r_div  <= (r_div & ~w_div_mask) | (dat_i[DIV_W-1:0] & w_div_mask);
        if (w_wr_ctrl) r_ctrl <= dat_i[2:0];
        if (w_push & w_full & ~w_pop)  r_ovf <= 1'b1;
        else if (w_wr_ctrl & dat_i[3]) r_ovf <= 1'b0;
        if (w_push_ok) r_wptr <= r_wptr + AW'(1);
        if (w_pop)     r_rptr <= r_rptr + AW'(1);
        case ({w_push_ok, w_pop})
          2'b10:   r_level <= r_level + LW'(1);
          2'b01:   r_level <= r_level - LW'(1);
          default: ;
        endcase
      end
    end

    // Baud counter reloads from DIV at every bit boundary, so DIV writes apply from the next bit.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_state  <= S_IDLE;
        r_baud   <= '0;
        r_bitcnt <= '0;
        r_shift  <= '0;
        r_tx     <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_tx <= 1'b1;
            if (w_pop) begin
              r_state <= S_START;
              r_tx    <= 1'b0;
              r_shift <= r_mem[r_rptr];
              r_baud  <= w_reload;
            end
          end
          S_START: begin
            if (w_bit_end) begin
              r_state  <= S_DATA;
              r_tx     <= r_shift[0];
              r_bitcnt <= '0;
              r_baud   <= w_reload;
            end else begin
              r_baud <= r_baud - DIV_W'(1);
            end
          end
          S_DATA: begin
            if (w_bit_end) begin
              r_baud <= w_reload;
              if (r_bitcnt == 3'(DATA_BITS-1)) begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end else begin
                r_bitcnt <= r_bitcnt + 3'd1;
                r_shift  <= r_shift >> 1;
                r_tx     <= r_shift[1];
              end
            end else begin
              r_baud <= r_baud - DIV_W'(1);
            end
          end
          S_STOP: begin
            if (w_bit_end) begin
              if (w_pop) begin
                r_state <= S_START;
                r_tx    <= 1'b0;
                r_shift <= r_mem[r_rptr];
                r_baud  <= w_reload;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_baud <= r_baud - DIV_W'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end

    always_comb begin
      w_status         = '0;
      w_status[0]      = w_empty;
      w_status[1]      = w_full;
      w_status[2]      = (r_state == S_IDLE);
      w_status[3]      = r_ovf;
      w_status[8 +: LW] = r_level;
    end

    assign w_rd[c] = (w_reg == 2'd1) ? 32'(r_div) :
                     (w_reg == 2'd2) ? w_status :
                     (w_reg == 2'd3) ? {29'd0, r_ctrl} : 32'd0;
    assign w_irq[c] = (r_ctrl[1] & w_empty & (r_state == S_IDLE)) | (r_ctrl[2] & r_ovf);
    assign stx_o[c] = r_tx;
    assign dbg_state_o[2*c +: 2] = r_state;
  end

  // Channels at or beyond N_CH match no entry and read back as zero.
  always_comb begin
    w_rdata = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (w_ch == 4'(c)) w_rdata = w_rd[c];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ack  <= 1'b0;
      r_dat  <= '0;
      r_intr <= 1'b0;
    end else begin
      r_ack  <= w_acc;
      r_dat  <= (w_acc & ~we_i) ? w_rdata : 32'd0;
      r_intr <= |w_irq;
    end
  end

  assign ack_o  = r_ack;
  assign dat_o  = r_dat;
  assign intr_o = r_intr;

endmodule

// File: tb/tb_uart_tx_mch.sv
// Directed bench for uart_tx_mch: a frame-timeline model predicts every serial output each cycle,
// and register reads go through an expected-value queue.
module tb_uart_tx_mch;
  localparam int N_CH = 4;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic [15:0]       adr_i = '0;
  logic [31:0]       dat_i = '0;
  logic              we_i = 1'b0;
  logic [3:0]        sel_i = '0;
  logic              stb_i = 1'b0;
  logic              cyc_i = 1'b0;
  logic [31:0]       dat_o;
  logic              ack_o;
  logic              intr_o;
  logic [N_CH-1:0]   stx_o;
  logic [2*N_CH-1:0] dbg_state_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  logic prev_ack = 1'b0;
  logic [31:0] exp_q[$];

  // Frame timeline: channel, first cycle of the start bit, bit period, data byte.
  int fr_ch[$];
  int fr_start[$];
  int fr_div[$];
  logic [7:0] fr_data[$];
  int last_end[N_CH];

  uart_tx_mch #(.N_CH(N_CH)) dut (
    .clk_i(clk), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .we_i(we_i), .sel_i(sel_i), .stb_i(stb_i), .cyc_i(cyc_i), .ack_o(ack_o),
    .intr_o(intr_o), .stx_o(stx_o), .dbg_state_o(dbg_state_o)
  );

  // Clock and cycle counter: after the n-th rising edge cyc == n.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  function automatic int sched(input int ch, input int earliest, input logic [7:0] d, input int div);
    int dd;
    int s;
    dd = (div < 1) ? 1 : div;
    s = (earliest > last_end[ch]) ? earliest : last_end[ch];
    fr_ch.push_back(ch);
    fr_start.push_back(s);
    fr_div.push_back(dd);
    fr_data.push_back(d);
    last_end[ch] = s + 10 * dd;
    return s;
  endfunction

  function automatic void model_reset();
    fr_ch.delete();
    fr_start.delete();
    fr_div.delete();
    fr_data.delete();
    for (int i = 0; i < N_CH; i++) last_end[i] = 0;
  endfunction

  function automatic logic [N_CH-1:0] model_stx(input int t);
    logic [N_CH-1:0] v;
    logic [7:0] b;
    int j;
    v = '1;
    for (int i = 0; i < fr_start.size(); i++) begin
      if (t >= fr_start[i] && t < fr_start[i] + 10 * fr_div[i]) begin
        j = (t - fr_start[i]) / fr_div[i];
        b = fr_data[i];
        if (j == 0)      v[fr_ch[i]] = 1'b0;
        else if (j == 9) v[fr_ch[i]] = 1'b1;
        else             v[fr_ch[i]] = b[j-1];
      end
    end
    return v;
  endfunction

  // Frames still waiting in the FIFO when a read is acked on edge t.
  function automatic int model_level(input int ch, input int t);
    int n;
    n = 0;
    for (int i = 0; i < fr_start.size(); i++) begin
      if (fr_ch[i] == ch && fr_start[i] >= t) n++;
    end
    return n;
  endfunction

  // Per-cycle compare against the model plus bus-protocol rules.
  always @(negedge clk) begin
    if (!rst_i && chk_en) begin
      check32("stx", 32'(stx_o), 32'(model_stx(cyc)));
      if (!ack_o) check32("dat_idle", dat_o, 32'd0);
      check32("ack_single", {31'd0, prev_ack & ack_o}, 32'd0);
    end
    prev_ack = ack_o;
  end

  task automatic bus_cycle(input logic [15:0] a, input logic [31:0] d, input logic w,
                           input logic [3:0] s, output logic [31:0] rd, output int t_ack);
    int n;
    @(posedge clk); #1;
    adr_i = a; dat_i = d; we_i = w; sel_i = s; cyc_i = 1'b1; stb_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack_o && n < 8);
    check32("ack_latency", 32'(n), 32'd1);
    rd = dat_o;
    t_ack = cyc;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                           output int t_ack);
    logic [31:0] rd;
    bus_cycle(a, d, 1'b1, s, rd, t_ack);
  endtask

  task automatic expect_read(input string name, input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    int t;
    exp_q.push_back(exp);
    bus_cycle(a, 32'd0, 1'b0, 4'hF, rd, t);
    check32(name, rd, exp_q.pop_front());
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int t, tc, tk, s, e;
    int st[3];
    logic [31:0] rd;
    logic [3:0] pat;
    logic [9:0] bits;
    logic [7:0] b2b [3];

    model_reset();
    b2b[0] = 8'h3C; b2b[1] = 8'h81; b2b[2] = 8'hF0;

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    check32("rst_stx", 32'(stx_o), 32'h0000_000F);
    check32("rst_ack", 32'(ack_o), 32'd0);
    check32("rst_intr", 32'(intr_o), 32'd0);
    check32("rst_dat", dat_o, 32'd0);
    rst_i = 1'b0;
    chk_en = 1'b1;
    expect_read("status0_reset", 16'h0008, 32'h0000_0005);
    expect_read("div0_reset", 16'h0004, 32'd16);

    // Held strobe on an invalid channel: ack toggles, data stays zero
    @(posedge clk); #1;
    adr_i = 16'h00F8; we_i = 1'b0; sel_i = 4'hF; cyc_i = 1'b1; stb_i = 1'b1;
    pat[0] = ack_o;
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      pat[k] = ack_o;
      if (ack_o) check32("invalid_rd_dat", dat_o, 32'd0);
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    check32("ack_pattern", 32'(pat), 32'h0000_000A);
    expect_read("invalid_read", 16'h00F8, 32'd0);

    // Single frame on ch1, DIV=4
    bus_write(16'h0014, 32'd4, 4'hF, t);
    bus_write(16'h001C, 32'd1, 4'h1, t);
    bus_write(16'h0010, 32'h0000_00A5, 4'h1, t);
    s = sched(1, t + 1, 8'hA5, 4);
    bits = 10'b1101001010;
    for (int j = 0; j < 10; j++) begin
      wait_cyc(t + 1 + 4 * j + 2);
      check32("a5_bit", 32'(stx_o[1]), 32'(bits[j]));
    end
    wait_cyc(s + 40);
    expect_read("status1_after", 16'h0018, 32'h0000_0005);

    // Write to a nonexistent channel is ignored
    bus_write(16'h0050, 32'h0000_0000, 4'h1, t);
    expect_read("status1_invalid_wr", 16'h0018, 32'h0000_0005);

    // Back-to-back frames on ch0, DIV=2
    bus_write(16'h0004, 32'd2, 4'hF, t);
    for (int i = 0; i < 3; i++) bus_write(16'h0000, 32'(b2b[i]), 4'h1, t);
    expect_read("status0_queued", 16'h0008, 32'h0000_0304);
    bus_write(16'h000C, 32'd1, 4'h1, tc);
    for (int i = 0; i < 3; i++) st[i] = sched(0, tc + 1, b2b[i], 2);
    check32("model_gap01", 32'(st[1] - st[0]), 32'd20);
    check32("model_gap12", 32'(st[2] - st[1]), 32'd20);
    for (int k = 0; k < 3; k++) begin
      wait_cyc(st[k] + 5);
      bus_cycle(16'h0008, 32'd0, 1'b0, 4'hF, rd, t);
      check32("b2b_level_model", 32'(rd[15:8]), 32'(model_level(0, t)));
      check32("b2b_level_lit", 32'(rd[15:8]), 32'(2 - k));
    end
    wait_cyc(last_end[0] + 1);
    expect_read("status0_drained", 16'h0008, 32'h0000_0005);

    // DIV=0 behaves as a one-clock bit period
    bus_write(16'h0004, 32'd0, 4'hF, t);
    expect_read("div0_zero", 16'h0004, 32'd0);
    bus_write(16'h0000, 32'h0000_005A, 4'h1, t);
    s = sched(0, t + 1, 8'h5A, 0);
    wait_cyc(t + 3);
    check32("div0_bit1", 32'(stx_o[0]), 32'd1);
    wait_cyc(last_end[0] + 2);

    // Overflow on disabled ch2
    for (int i = 0; i < 17; i++) bus_write(16'h0020, 32'(i), 4'h1, t);
    expect_read("status2_ovf", 16'h0028, 32'h0000_100E);
    bus_write(16'h002C, 32'h0000_0004, 4'h1, tc);
    @(negedge clk);
    check32("ovf_intr_lag", 32'(intr_o), 32'd0);
    @(negedge clk);
    check32("ovf_intr_rise", 32'(intr_o), 32'd1);
    bus_write(16'h002C, 32'h0000_000C, 4'h1, tk);
    @(negedge clk);
    check32("ovf_clr_lag", 32'(intr_o), 32'd1);
    @(negedge clk);
    check32("ovf_clr_drop", 32'(intr_o), 32'd0);
    expect_read("status2_clr", 16'h0028, 32'h0000_1006);
    expect_read("ctrl2_read", 16'h002C, 32'h0000_0004);

    // Byte lane select on DIV
    bus_write(16'h0034, 32'hFFFF_FF03, 4'b0001, t);
    expect_read("div3_lane", 16'h0034, 32'd3);

    // Empty interrupt on ch3
    bus_write(16'h0030, 32'h0000_003C, 4'h1, t);
    bus_write(16'h003C, 32'h0000_0003, 4'h1, tc);
    s = sched(3, tc + 1, 8'h3C, 3);
    e = s + 30;
    check32("model_end3", 32'(e - tc), 32'd31);
    for (int x = tc; x <= e + 1; x++) begin
      wait_cyc(x);
      check32("empty_intr", 32'(intr_o), 32'(x >= e + 1));
    end

    // Reset in the middle of a frame on ch1
    bus_write(16'h0010, 32'h0000_0000, 4'h1, t);
    s = sched(1, t + 1, 8'h00, 4);
    wait_cyc(t + 10);
    @(posedge clk); #1;
    rst_i = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check32("midrst_stx", 32'(stx_o), 32'h0000_000F);
      check32("midrst_ack", 32'(ack_o), 32'd0);
      check32("midrst_intr", 32'(intr_o), 32'd0);
    end
    rst_i = 1'b0;
    expect_read("status0_rst", 16'h0008, 32'h0000_0005);
    expect_read("div0_rst", 16'h0004, 32'd16);
    expect_read("ctrl1_rst", 16'h001C, 32'd0);
    expect_read("status2_rst", 16'h0028, 32'h0000_0005);
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
